// File: rtl/vcmac_ctrl.sv
// vcmac_ctrl: sequencer for the VCMAC vector complex-MAC array.
// Streams matrix/vector operand addresses row by row. It drives the VCMAC
// multiply/accumulate enables through a three-stage tag pipeline and emits
// one result write per matrix row. It also keeps a sticky per-job overflow flag.
// Optional build macro: VCMAC_CTRL_OVF_ABORT_EN. When it is defined, the first
// result write that sees overflow aborts the job early.
module vcmac_ctrl #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8,
  parameter int ROW_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ROW_W-1:0]  rows,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_s,
  input  logic              abs_mode,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              w_en_mult,
  output logic              w_en_acc,
  output logic              acc,
  output logic              abs,
  input  logic              overflow,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  localparam logic [LEN_W-1:0]  LEN_ONE  = 1;
  localparam logic [ROW_W-1:0]  ROW_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t              state_q;
  logic [LEN_W-1:0]    len_q;
  logic [ROW_W-1:0]    rows_q;
  logic [LEN_W-1:0]    kCnt_q;
  logic [ROW_W-1:0]    rCnt_q;
  logic [ADDR_W-1:0]   baseB_q;
  logic [ADDR_W-1:0]   rowAddr_q;

  logic                rdEn_q;
  logic [ADDR_W-1:0]   rdAddrA_q;
  logic [ADDR_W-1:0]   rdAddrB_q;
  logic                wEnMult_q;
  logic                s1First_q;
  logic                s1Last_q;
  logic                wEnAcc_q;
  logic                acc_q;
  logic                s2Last_q;
  logic                abs_q;
  logic                wrEn_q;
  logic [ADDR_W-1:0]   wrAddr_q;
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;

  logic                lastK;
  logic                lastR;
  logic                pipeEmpty;
  logic [LEN_W-1:0]    kCnt_d;
  logic [ROW_W-1:0]    rCnt_d;
  logic [ADDR_W-1:0]   rdAddrA_d;
  logic [ADDR_W-1:0]   rdAddrB_d;

  // Next term position. The matrix is row-major, so the A address just counts
  // up. The B address restarts at the vector base on every new row.
  always_comb begin
    lastK     = (kCnt_q == (len_q - LEN_ONE));
    lastR     = (rCnt_q == (rows_q - ROW_ONE));
    pipeEmpty = !rdEn_q && !wEnMult_q && !wEnAcc_q;
    kCnt_d    = lastK ? '0 : (kCnt_q + LEN_ONE);
    rCnt_d    = lastK ? (rCnt_q + ROW_ONE) : rCnt_q;
    rdAddrA_d = rdAddrA_q + ADDR_ONE;
    rdAddrB_d = lastK ? baseB_q : (rdAddrB_q + ADDR_ONE);
  end

  // Job FSM, read issue, tag pipeline and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      rows_q    <= '0;
      kCnt_q    <= '0;
      rCnt_q    <= '0;
      baseB_q   <= '0;
      rowAddr_q <= '0;
      rdEn_q    <= 1'b0;
      rdAddrA_q <= '0;
      rdAddrB_q <= '0;
      wEnMult_q <= 1'b0;
      s1First_q <= 1'b0;
      s1Last_q  <= 1'b0;
      wEnAcc_q  <= 1'b0;
      acc_q     <= 1'b0;
      s2Last_q  <= 1'b0;
      abs_q     <= 1'b0;
      wrEn_q    <= 1'b0;
      wrAddr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      wEnMult_q <= rdEn_q;
      s1First_q <= rdEn_q && (kCnt_q == '0);
      s1Last_q  <= rdEn_q && lastK;
      wEnAcc_q  <= wEnMult_q;
      acc_q     <= wEnMult_q && !s1First_q;
      s2Last_q  <= wEnMult_q && s1Last_q;
      wrEn_q    <= wEnAcc_q && s2Last_q;
      if (wEnAcc_q && s2Last_q) begin
        wrAddr_q  <= rowAddr_q;
        rowAddr_q <= rowAddr_q + ADDR_ONE;
      end
      if (wrEn_q && overflow) begin
        ovf_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          rdEn_q <= 1'b0;
          abs_q  <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            len_q     <= len;
            rows_q    <= rows;
            baseB_q   <= base_b;
            rowAddr_q <= base_s;
            kCnt_q    <= '0;
            rCnt_q    <= '0;
            ovf_q     <= 1'b0;
            if ((len == '0) || (rows == '0)) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ISSUE;
              busy_q    <= 1'b1;
              abs_q     <= abs_mode;
              rdEn_q    <= 1'b1;
              rdAddrA_q <= base_a;
              rdAddrB_q <= base_b;
            end
          end
        end
        ISSUE: begin
          if (lastK && lastR) begin
            rdEn_q  <= 1'b0;
            state_q <= DRAIN;
          end else begin
            rdEn_q    <= 1'b1;
            kCnt_q    <= kCnt_d;
            rCnt_q    <= rCnt_d;
            rdAddrA_q <= rdAddrA_d;
            rdAddrB_q <= rdAddrB_d;
          end
        end
        DRAIN: begin
          rdEn_q <= 1'b0;
          if (pipeEmpty) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            abs_q   <= 1'b0;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

`ifdef VCMAC_CTRL_OVF_ABORT_EN
      if (wrEn_q && overflow && (state_q != IDLE)) begin
        state_q   <= DRAIN;
        rdEn_q    <= 1'b0;
        wEnMult_q <= 1'b0;
        wEnAcc_q  <= 1'b0;
        acc_q     <= 1'b0;
        wrEn_q    <= 1'b0;
        done_q    <= 1'b0;
        busy_q    <= 1'b1;
      end
`else
`endif
    end
  end

  assign rd_en     = rdEn_q;
  assign rd_addr_a = rdAddrA_q;
  assign rd_addr_b = rdAddrB_q;
  assign w_en_mult = wEnMult_q;
  assign w_en_acc  = wEnAcc_q;
  assign acc       = acc_q;
  assign abs       = abs_q;
  assign wr_en     = wrEn_q;
  assign wr_addr   = wrAddr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_vcmac_ctrl.sv
// tb_vcmac_ctrl: scoreboard bench for vcmac_ctrl.
// Each job pushes its expected strobe events into per-strobe queues, and a
// negedge monitor pops and compares them whenever the DUT asserts a strobe.
// Honours VCMAC_CTRL_OVF_ABORT_EN in the same way as the design.
module tb_vcmac_ctrl;

  typedef struct {
    int when;
    int a;
    int b;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic [7:0] rows;
  logic [9:0] base_a;
  logic [9:0] base_b;
  logic [9:0] base_s;
  logic       abs_mode;
  logic       rd_en;
  logic [9:0] rd_addr_a;
  logic [9:0] rd_addr_b;
  logic       w_en_mult;
  logic       w_en_acc;
  logic       acc;
  logic       abs;
  logic       overflow;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic       busy;
  logic       done;
  logic       ovf;

  ev_t rdQ[$];
  ev_t mulQ[$];
  ev_t accQ[$];
  ev_t wrQ[$];
  ev_t doneQ[$];
  ev_t mEv;

  int  cyc = 0;
  int  base = 0;
  int  busyLo = 1;
  int  busyHi = 0;
  bit  absExp = 1'b0;
  bit  monOn = 1'b0;
  bit  inWin;
  int  nVec = 0;
  int  nFail = 0;

  vcmac_ctrl #(.ADDR_W(10), .LEN_W(8), .ROW_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .rows(rows),
    .base_a(base_a), .base_b(base_b), .base_s(base_s), .abs_mode(abs_mode),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .w_en_mult(w_en_mult), .w_en_acc(w_en_acc), .acc(acc), .abs(abs),
    .overflow(overflow), .wr_en(wr_en), .wr_addr(wr_addr),
    .busy(busy), .done(done), .ovf(ovf)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Free-running edge counter used to time-stamp expected events.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: actual %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Spec cycle c of the current job maps to counter value base + c - 1.
  task automatic pushEv(input int kind, input int c, input int a, input int b);
    ev_t e;
    e.when = base + c - 1;
    e.a = a;
    e.b = b;
    case (kind)
      0: rdQ.push_back(e);
      1: mulQ.push_back(e);
      2: accQ.push_back(e);
      3: wrQ.push_back(e);
      default: doneQ.push_back(e);
    endcase
  endtask

  // Monitor: pops the matching expectation on every asserted strobe.
  always @(negedge clk) begin
    if (monOn) begin
      if (rd_en) begin
        if (rdQ.size() == 0) chk("rd_en spurious", int'(rd_en), 0);
        else begin
          mEv = rdQ.pop_front();
          chk("rd_en cycle", cyc, mEv.when);
          chk("rd_addr_a", int'(rd_addr_a), mEv.a);
          chk("rd_addr_b", int'(rd_addr_b), mEv.b);
        end
      end
      if (w_en_mult) begin
        if (mulQ.size() == 0) chk("w_en_mult spurious", int'(w_en_mult), 0);
        else begin
          mEv = mulQ.pop_front();
          chk("w_en_mult cycle", cyc, mEv.when);
        end
      end
      if (w_en_acc) begin
        if (accQ.size() == 0) chk("w_en_acc spurious", int'(w_en_acc), 0);
        else begin
          mEv = accQ.pop_front();
          chk("w_en_acc cycle", cyc, mEv.when);
          chk("acc", int'(acc), mEv.a);
        end
      end
      if (wr_en) begin
        if (wrQ.size() == 0) chk("wr_en spurious", int'(wr_en), 0);
        else begin
          mEv = wrQ.pop_front();
          chk("wr_en cycle", cyc, mEv.when);
          chk("wr_addr", int'(wr_addr), mEv.a);
        end
      end
      if (done) begin
        if (doneQ.size() == 0) chk("done spurious", int'(done), 0);
        else begin
          mEv = doneQ.pop_front();
          chk("done cycle", cyc, mEv.when);
          chk("ovf at done", int'(ovf), mEv.a);
        end
      end
      inWin = (cyc >= busyLo) && (cyc <= busyHi);
      chk("busy", int'(busy), int'(inWin));
      chk("abs", int'(abs), int'(inWin && absExp));
    end
  end

  // Pulses start for one edge and records the acceptance time base.
  task automatic applyStimulus(input int k, input int r, input int ba, input int bb,
                               input int bs, input bit am, input int nBusy);
    @(negedge clk);
    len = k[7:0];
    rows = r[7:0];
    base_a = ba[9:0];
    base_b = bb[9:0];
    base_s = bs[9:0];
    abs_mode = am;
    start = 1'b1;
    @(posedge clk);
    #1;
    base = cyc;
    start = 1'b0;
    busyLo = base;
    busyHi = base + nBusy - 1;
    absExp = am;
  endtask

  task automatic runTo(input int c);
    while (cyc < base + c) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, " rd_en"}, int'(rd_en), 0);
    chk({tag, " rd_addr_a"}, int'(rd_addr_a), 0);
    chk({tag, " rd_addr_b"}, int'(rd_addr_b), 0);
    chk({tag, " w_en_mult"}, int'(w_en_mult), 0);
    chk({tag, " w_en_acc"}, int'(w_en_acc), 0);
    chk({tag, " acc"}, int'(acc), 0);
    chk({tag, " abs"}, int'(abs), 0);
    chk({tag, " wr_en"}, int'(wr_en), 0);
    chk({tag, " wr_addr"}, int'(wr_addr), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " ovf"}, int'(ovf), 0);
  endtask

  task automatic checkDrained(input string tag);
    chk({tag, " rd events missing"}, rdQ.size(), 0);
    chk({tag, " mult events missing"}, mulQ.size(), 0);
    chk({tag, " acc events missing"}, accQ.size(), 0);
    chk({tag, " wr events missing"}, wrQ.size(), 0);
    chk({tag, " done events missing"}, doneQ.size(), 0);
    rdQ.delete(); mulQ.delete(); accQ.delete(); wrQ.delete(); doneQ.delete();
  endtask

  // K=3, R=2 job from bases 0x10/0x40/0x80: addresses 0x10..0x15, B cycles 0x40..0x42.
  task automatic pushNominal32();
    for (int j = 0; j < 6; j++) begin
      pushEv(0, 1 + j, 'h10 + j, 'h40 + (j % 3));
      pushEv(1, 2 + j, 0, 0);
      pushEv(2, 3 + j, ((j % 3) != 0) ? 1 : 0, 0);
    end
    pushEv(3, 6, 'h80, 0);
    pushEv(3, 9, 'h81, 0);
    pushEv(4, 10, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; rows = '0;
    base_a = '0; base_b = '0; base_s = '0; abs_mode = 1'b0; overflow = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    monOn = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reset idle");

    // Nominal 3x2 job, with a start pulse mid-job that must be ignored.
    applyStimulus(3, 2, 'h10, 'h40, 'h80, 1'b1, 9);
    pushNominal32();
    repeat (4) @(negedge clk);
    start = 1'b1; len = 8'd1; rows = 8'd1; base_a = 10'h200; base_s = 10'h300;
    @(negedge clk);
    start = 1'b0;
    runTo(12);
    checkDrained("job 3x2");

    // One term per row: every accumulate is a load, writes back-to-back.
    applyStimulus(1, 4, 'h10, 'h40, 'h80, 1'b0, 7);
    for (int j = 0; j < 4; j++) begin
      pushEv(0, 1 + j, 'h10 + j, 'h40);
      pushEv(1, 2 + j, 0, 0);
      pushEv(2, 3 + j, 0, 0);
      pushEv(3, 4 + j, 'h80 + j, 0);
    end
    pushEv(4, 8, 0, 0);
    runTo(10);
    checkDrained("job 1x4");

    // Overflow seen on the first row write of a 2x3 job.
`ifdef VCMAC_CTRL_OVF_ABORT_EN
    applyStimulus(2, 3, 'h10, 'h40, 'h80, 1'b0, 6);
    for (int j = 0; j < 5; j++) pushEv(0, 1 + j, 'h10 + j, 'h40 + (j % 2));
    for (int j = 0; j < 4; j++) pushEv(1, 2 + j, 0, 0);
    for (int j = 0; j < 3; j++) pushEv(2, 3 + j, j % 2, 0);
    pushEv(3, 5, 'h80, 0);
    pushEv(4, 7, 1, 0);
`else
    applyStimulus(2, 3, 'h10, 'h40, 'h80, 1'b0, 9);
    for (int j = 0; j < 6; j++) begin
      pushEv(0, 1 + j, 'h10 + j, 'h40 + (j % 2));
      pushEv(1, 2 + j, 0, 0);
      pushEv(2, 3 + j, j % 2, 0);
    end
    pushEv(3, 5, 'h80, 0);
    pushEv(3, 7, 'h81, 0);
    pushEv(3, 9, 'h82, 0);
    pushEv(4, 10, 1, 0);
`endif
    repeat (5) @(negedge clk);
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    runTo(12);
    checkDrained("job overflow");

    // Degenerate jobs: done in cycle 1 only; ovf cleared by the new start.
    applyStimulus(4, 0, 'h10, 'h40, 'h80, 1'b1, 0);
    pushEv(4, 1, 0, 0);
    runTo(5);
    checkDrained("rows=0");
    applyStimulus(0, 5, 'h10, 'h40, 'h80, 1'b0, 0);
    pushEv(4, 1, 0, 0);
    runTo(5);
    checkDrained("len=0");

    // Address wrap at the top of the 10-bit space.
    applyStimulus(2, 1, 'h3FF, 'h3FF, 'h3FF, 1'b1, 5);
    pushEv(0, 1, 'h3FF, 'h3FF);
    pushEv(0, 2, 'h000, 'h000);
    pushEv(1, 2, 0, 0);
    pushEv(1, 3, 0, 0);
    pushEv(2, 3, 0, 0);
    pushEv(2, 4, 1, 0);
    pushEv(3, 5, 'h3FF, 0);
    pushEv(4, 6, 0, 0);
    runTo(8);
    checkDrained("wrap");

    // Reset in the cycle after the second read, then a clean rerun.
    applyStimulus(3, 2, 'h10, 'h40, 'h80, 1'b1, 9);
    for (int j = 0; j < 3; j++) pushEv(0, 1 + j, 'h10 + j, 'h40 + j);
    pushEv(1, 2, 0, 0);
    pushEv(1, 3, 0, 0);
    pushEv(2, 3, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    busyHi = base + 2;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid-job reset");
    runTo(8);
    checkDrained("mid-job reset");
    applyStimulus(3, 2, 'h10, 'h40, 'h80, 1'b1, 9);
    pushNominal32();
    runTo(12);
    checkDrained("job after reset");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
